// File: rtl/led_bar_meter.sv
// -----------------------------------------------------------------------------
// led_bar_meter
//
// N-LED bar-graph meter. A level source strobes a level in. The meter saturates
// the level to NUM_LEDS. The displayed level (disp) attacks instantly and
// decays one step every DECAY_CYCLES cycles. The LEDs are driven as a
// thermometer bar or as a single dot. The LED pattern is registered, so it
// follows disp/peak one edge later.
//
// Optional feature macro: LED_BAR_PEAK_EN
//   defined   : peak-hold FSM (TRACK/HOLD/FALL). The peak marker is ORed into
//               leds.
//   undefined : no peak logic is built. peak mirrors disp and no marker is drawn.
//
// Ports
//   clk          rising-edge system clock
//   rst          synchronous, active-high reset
//   level        requested level, 0..NUM_LEDS (larger values clamp to all-on)
//   level_valid  level is sampled on any clk edge where this is high
//   mode         0 = bar (thermometer), 1 = dot (single LED)
//   leds         registered LED drive, bit 0 = first LED
//   peak         current peak-hold level (registered)
//
// Handshake: level_valid is a one-way strobe with no back-pressure. The meter
// accepts a sample on every edge where level_valid is high, and there is no
// ready signal.
// -----------------------------------------------------------------------------
module led_bar_meter #(
  parameter int NUM_LEDS     = 16,
  parameter int LEVEL_W      = $clog2(NUM_LEDS + 1),
  parameter int DECAY_CYCLES = 5_000_000,
  parameter int HOLD_CYCLES  = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEVEL_W-1:0]  level,
  input  logic                level_valid,
  input  logic                mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic [LEVEL_W-1:0]  peak
);

  localparam int               DW         = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [DW-1:0]    DECAY_LAST = DW'(DECAY_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] MAX_LVL  = LEVEL_W'(NUM_LEDS);

  logic [LEVEL_W-1:0]  lvl_c;
  logic [LEVEL_W-1:0]  disp, disp_next;
  logic [LEVEL_W-1:0]  tgt, tgt_next;
  logic [DW-1:0]       decay_cnt, decay_cnt_next;
  logic [LEVEL_W-1:0]  peak_q;
  logic [LEVEL_W-1:0]  disp_m1;
  logic [NUM_LEDS-1:0] leds_next;

  assign lvl_c = (level > MAX_LVL) ? MAX_LVL : level;

  // Level tracking. A sample at or above the display attacks at once.
  // Anything below becomes the new decay target. The decay decision uses the
  // target as updated on this same edge.
  always_comb begin
    tgt_next       = tgt;
    disp_next      = disp;
    decay_cnt_next = '0;
    if (level_valid) tgt_next = lvl_c;
    if (level_valid && (lvl_c >= disp)) begin
      disp_next = lvl_c;
    end else if (disp > tgt_next) begin
      if (decay_cnt == DECAY_LAST) disp_next = disp - LEVEL_W'(1);
      else                         decay_cnt_next = decay_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp      <= '0;
      tgt       <= '0;
      decay_cnt <= '0;
    end else begin
      disp      <= disp_next;
      tgt       <= tgt_next;
      decay_cnt <= decay_cnt_next;
    end
  end

`ifdef LED_BAR_PEAK_EN
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    PK_TRACK = 2'd0,
    PK_HOLD  = 2'd1,
    PK_FALL  = 2'd2
  } peak_state_t;

  // peak_state is the observable FSM state for checkers and probes.
  peak_state_t         peak_state, peak_state_next;
  logic [HW-1:0]       hold_cnt, hold_cnt_next;
  logic [DW-1:0]       fall_cnt, fall_cnt_next;
  logic [LEVEL_W-1:0]  peak_next, peak_fall;
  logic [LEVEL_W-1:0]  peak_m1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_state <= PK_TRACK;
      peak_q     <= '0;
      hold_cnt   <= '0;
      fall_cnt   <= '0;
    end else begin
      peak_state <= peak_state_next;
      peak_q     <= peak_next;
      hold_cnt   <= hold_cnt_next;
      fall_cnt   <= fall_cnt_next;
    end
  end

  // Next-state logic, evaluated against the display value being written now
  always_comb begin
    peak_state_next = peak_state;
    peak_next       = peak_q;
    hold_cnt_next   = hold_cnt;
    fall_cnt_next   = fall_cnt;
    peak_fall       = peak_q;
    unique case (peak_state)
      PK_TRACK: begin
        if (disp_next >= peak_q) begin
          peak_next = disp_next;
        end else begin
          peak_state_next = PK_HOLD;
          hold_cnt_next   = '0;
        end
      end
      PK_HOLD: begin
        if (disp_next >= peak_q) begin
          peak_next       = disp_next;
          peak_state_next = PK_TRACK;
        end else if (hold_cnt == HOLD_LAST) begin
          peak_state_next = PK_FALL;
          fall_cnt_next   = '0;
        end else begin
          hold_cnt_next = hold_cnt + HW'(1);
        end
      end
      PK_FALL: begin
        if (fall_cnt == DECAY_LAST) begin
          fall_cnt_next = '0;
          if (peak_q != '0) peak_fall = peak_q - LEVEL_W'(1);
        end else begin
          fall_cnt_next = fall_cnt + DW'(1);
        end
        if (disp_next >= peak_fall) begin
          peak_next       = disp_next;
          peak_state_next = PK_TRACK;
        end else begin
          peak_next = peak_fall;
        end
      end
      default: begin
        peak_state_next = PK_TRACK;
        peak_next       = disp_next;
      end
    endcase
  end

  assign peak_m1 = peak_q - LEVEL_W'(1);
`else
  assign peak_q = disp;
`endif

  assign disp_m1 = disp - LEVEL_W'(1);

  // Output encode from the registered disp/peak
  always_comb begin
    leds_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (mode) leds_next[i] = (disp != '0) && (LEVEL_W'(i) == disp_m1);
      else      leds_next[i] = (LEVEL_W'(i) < disp);
`ifdef LED_BAR_PEAK_EN
      if ((peak_q != '0) && (LEVEL_W'(i) == peak_m1)) leds_next[i] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) leds <= '0;
    else     leds <= leds_next;
  end

  assign peak = peak_q;

endmodule
